// File: rtl/syscall_responder.sv
// syscall_responder: services the core's syscall requests (print int, print
// char, exit) and keeps the core stalled until the service finishes. Bytes
// go out on a valid/ready stream. Exit sets a sticky halt that only reset
// clears.
module syscall_responder #(
  parameter logic [31:0] CODE_PRINT_INT  = 32'd1,
  parameter logic [31:0] CODE_EXIT       = 32'd10,
  parameter logic [31:0] CODE_PRINT_CHAR = 32'd11,
  parameter logic [31:0] CODE_EXIT2      = 32'd17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_code,
  input  logic [31:0] req_arg,
  output logic        stall,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        halted,
  output logic [31:0] exit_code,
  output logic        unknown
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHAR,
    S_SIGN,
    S_DIV,
    S_EMIT,
    S_HALT
  } state_t;

  // 2^32-1 has ten decimal digits, so ten entries always suffice.
  localparam int         STACK_DEPTH = 10;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  state_t      state;
  logic [31:0] mag;        // dividend; quotient bits shift in from the LSB
  logic [3:0]  rem;        // partial remainder, always below 10
  logic [4:0]  bit_cnt;    // quotient bit being produced within a digit
  logic [3:0]  sp;         // number of digits held on the stack
  logic [3:0]  digit_stack [STACK_DEPTH];

  // Divider datapath signals.
  logic [4:0]  trial;
  logic [4:0]  trial_sub;
  logic        div_ge;
  logic [3:0]  rem_next;
  logic [31:0] mag_next;
  logic        digit_done;
  logic [3:0]  pop_idx;

  // Ready and stall decode straight from the state register.
  assign req_ready = (state == S_IDLE);
  assign stall     = (state != S_IDLE);

  // One restoring-division step: bring in the next dividend bit, subtract 10
  // when it fits, and shift the resulting quotient bit into the low end.
  // NOTE: every always_comb output gets a value on every path (here
  // unconditionally), so no latch can be inferred.
  always_comb begin
    trial      = {rem, mag[31]};
    trial_sub  = trial - 5'd10;
    div_ge     = (trial >= 5'd10);
    rem_next   = div_ge ? trial_sub[3:0] : trial[3:0];
    mag_next   = {mag[30:0], div_ge};
    digit_done = (state == S_DIV) && (bit_cnt == 5'd31);
    pop_idx    = sp - 4'd2;
  end

  // Push each finished remainder onto the digit stack.
  // NOTE: the stack storage has no reset; the pointer sp defines which
  // entries are live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (digit_done) begin
      digit_stack[sp] <= rem_next;
    end
  end

  // Service FSM with registered byte stream, halt and unknown outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      mag       <= '0;
      rem       <= '0;
      bit_cnt   <= '0;
      sp        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      halted    <= 1'b0;
      exit_code <= '0;
      unknown   <= 1'b0;
    end else begin
      unknown <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            rem     <= '0;
            bit_cnt <= '0;
            sp      <= '0;
            if (req_code == CODE_PRINT_CHAR) begin
              out_data  <= req_arg[7:0];
              out_valid <= 1'b1;
              state     <= S_CHAR;
            end else if (req_code == CODE_PRINT_INT) begin
              if (req_arg[31]) begin
                // Negation as unsigned makes 0x80000000 print 2147483648.
                mag       <= -req_arg;
                out_data  <= ASCII_MINUS;
                out_valid <= 1'b1;
                state     <= S_SIGN;
              end else begin
                mag   <= req_arg;
                state <= S_DIV;
              end
            end else if (req_code == CODE_EXIT) begin
              halted    <= 1'b1;
              exit_code <= '0;
              state     <= S_HALT;
            end else if (req_code == CODE_EXIT2) begin
              halted    <= 1'b1;
              exit_code <= req_arg;
              state     <= S_HALT;
            end else begin
              // Unsupported code: consumed, flagged, nothing printed.
              unknown <= 1'b1;
            end
          end
        end

        S_CHAR: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        S_SIGN: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_DIV;
          end
        end

        S_DIV: begin
          mag <= mag_next;
          if (bit_cnt == 5'd31) begin
            // Digit complete: remainder is pushed by the stack block.
            sp      <= sp + 4'd1;
            rem     <= '0;
            bit_cnt <= '0;
            if (mag_next == '0) begin
              // The digit just produced is the most significant one, so
              // present it directly instead of reading it back.
              out_data  <= ASCII_ZERO + {4'b0000, rem_next};
              out_valid <= 1'b1;
              state     <= S_EMIT;
            end
          end else begin
            rem     <= rem_next;
            bit_cnt <= bit_cnt + 5'd1;
          end
        end

        S_EMIT: begin
          if (out_ready) begin
            if (sp == 4'd1) begin
              sp        <= '0;
              out_valid <= 1'b0;
              state     <= S_IDLE;
            end else begin
              sp       <= sp - 4'd1;
              out_data <= ASCII_ZERO + {4'b0000, digit_stack[pop_idx]};
            end
          end
        end

        S_HALT: begin
          // Terminal until reset.
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_responder.sv
// Self-checking bench for syscall_responder. Expected byte streams come from
// $sformatf of the signed argument; expected timing comes from the digit
// count (32 divide cycles per digit, one byte per cycle when unthrottled).
module tb_syscall_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_code;
  logic [31:0] req_arg;
  logic        stall;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        halted;
  logic [31:0] exit_code;
  logic        unknown;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_q [$];

  syscall_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_code  (req_code),
    .req_arg   (req_arg),
    .stall     (stall),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .halted    (halted),
    .exit_code (exit_code),
    .unknown   (unknown)
  );

  always #5 clk = ~clk;

  // Byte sink: record every accepted byte.
  always @(posedge clk) begin
    if (reset_n && out_valid && out_ready) rx_q.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s: observed=\"%s\" expected=\"%s\"", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_stall"},     stall,     0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_halted"},    halted,    0);
    check({tag, "_exit_code"}, exit_code, 0);
    check({tag, "_unknown"},   unknown,   0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  // Present one request and follow it until req_ready returns. Latencies are
  // counted in cycles after the accepting edge (1 = the cycle right after).
  task automatic run_service(input logic [31:0] code, input logic [31:0] arg,
                             input bit rand_ready, output string got,
                             output int first_lat, output int done_lat,
                             output int stall_cyc, output int stab_err,
                             output logic unk1);
    logic       pv, pr;
    logic [7:0] pd;
    rx_q.delete();
    first_lat = -1; done_lat = -1; stall_cyc = 0; stab_err = 0; unk1 = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_code = code; req_arg = arg;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    pv = 1'b0; pr = out_ready; pd = '0;
    @(posedge clk);
    for (int k = 1; k <= 1500; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        unk1      = unknown;
      end
      if (pv && !pr && !(out_valid && out_data == pd)) stab_err++;
      if (out_valid && first_lat < 0) first_lat = k;
      if (stall) stall_cyc++;
      if (req_ready) begin
        done_lat = k;
        break;
      end
      pv = out_valid; pd = out_data;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      pr = out_ready;
    end
    out_ready = 1'b1;
    got = "";
    foreach (rx_q[i]) got = {got, $sformatf("%c", rx_q[i])};
  endtask

  // Reference: decimal text of the signed argument plus its timing.
  task automatic check_print_int(input string tag, input logic [31:0] arg,
                                 input bit rand_ready);
    string got, exp;
    int    fl, dl, sc, se, d, neg;
    logic  u;
    exp = $sformatf("%0d", $signed(arg));
    neg = arg[31] ? 1 : 0;
    d   = exp.len() - neg;
    run_service(32'd1, arg, rand_ready, got, fl, dl, sc, se, u);
    check_str({tag, "_bytes"}, got, exp);
    check({tag, "_first_lat"}, fl, neg ? 1 : 32 * d + 1);
    check({tag, "_stable"}, se, 0);
    if (rand_ready) begin
      check({tag, "_done"}, (dl > 0) ? 1 : 0, 1);
    end else begin
      check({tag, "_done_lat"}, dl, neg + 33 * d + 1);
      check({tag, "_stall_cyc"}, sc, neg + 33 * d);
    end
  endtask

  initial begin
    string       got;
    int          fl, dl, sc, se;
    logic        u;
    logic [31:0] dir_args [5];
    logic [31:0] r;

    reset_n = 1'b0; req_valid = 1'b0; req_code = '0; req_arg = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("rst_held");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("rst_released");

    // Print char 'A' with the sink always ready.
    run_service(32'd11, 32'h0000_0041, 1'b0, got, fl, dl, sc, se, u);
    check_str("char_bytes", got, "A");
    check("char_first_lat", fl, 1);
    check("char_done_lat", dl, 2);
    check("char_stall_cyc", sc, 1);

    // Directed integers, including zero and both signed extremes.
    dir_args[0] = 32'd0;
    dir_args[1] = 32'd123;
    dir_args[2] = 32'd2147483647;
    dir_args[3] = 32'hFFFF_FFFB;
    dir_args[4] = 32'h8000_0000;
    foreach (dir_args[i]) check_print_int($sformatf("int%0d", i), dir_args[i], 1'b0);

    // Sink backpressure.
    check_print_int("int4096_bp", 32'd4096, 1'b1);
    check_print_int("intneg_bp", 32'hFFFF_FC18, 1'b1);

    // Random arguments, random sink readiness on half of them.
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0:       r = $urandom;
        1:       r = $urandom_range(0, 999);
        default: r = -$urandom_range(1, 99999);
      endcase
      check_print_int($sformatf("rand%0d", i), r, i[0]);
    end

    // Unsupported code.
    run_service(32'd99, 32'd7, 1'b0, got, fl, dl, sc, se, u);
    check("unk_pulse", u, 1);
    check("unk_done_lat", dl, 1);
    check_str("unk_bytes", got, "");
    @(negedge clk);
    check("unk_cleared", unknown, 0);
    check("unk_ready", req_ready, 1);

    // Exit with code, then blocked further requests.
    @(negedge clk);
    req_valid = 1'b1; req_code = 32'd17; req_arg = 32'd42;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("exit2_halted", halted, 1);
    check("exit2_code", exit_code, 42);
    check("exit2_stall", stall, 1);
    check("exit2_ready", req_ready, 0);
    rx_q.delete();
    req_valid = 1'b1; req_code = 32'd11; req_arg = 32'h5A;
    repeat (5) @(negedge clk);
    check("halt_ready", req_ready, 0);
    req_valid = 1'b0;
    check("halt_no_bytes", rx_q.size(), 0);
    check("halt_stall", stall, 1);
    check("halt_out_valid", out_valid, 0);
    check("halt_code_held", exit_code, 42);
    pulse_reset();
    check_reset_values("after_halt");

    @(negedge clk);
    req_valid = 1'b1; req_code = 32'd10; req_arg = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("exit_halted", halted, 1);
    check("exit_code0", exit_code, 0);
    pulse_reset();

    // Reset in the middle of a divide.
    rx_q.delete();
    @(negedge clk);
    req_valid = 1'b1; req_code = 32'd1; req_arg = 32'd12345;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (50) @(negedge clk);
    check("middiv_stall", stall, 1);
    reset_n = 1'b0;
    #1;
    check_reset_values("middiv_rst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("middiv_no_bytes", rx_q.size(), 0);
    check_print_int("after_rst", 32'd77, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/syscall_responder.md
# syscall_responder

Hardware service end of the core's `syscall` path: it accepts a syscall request carrying the `$v0` service code and `$a0` argument, performs the service, and holds the core stalled until the service completes. Output bytes go out on a valid/ready byte stream for the console model, and exit sets a sticky halt. It sits beside the decode stage, which raises the request when it decodes `syscall`; the bench stops simulation on `halted`.

## Interface

Parameters:
- `CODE_PRINT_INT`, 1: print `$a0` as signed decimal.
- `CODE_EXIT`, 10: halt with exit code 0.
- `CODE_PRINT_CHAR`, 11: print `$a0[7:0]`.
- `CODE_EXIT2`, 17: halt with exit code `$a0`.

Ports:
- `clk` in 1: sole clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: decode presents a syscall.
- `req_ready` out 1: responder can accept; high only in IDLE.
- `req_code` in 32: `$v0` value.
- `req_arg` in 32: `$a0` value.
- `stall` out 1: core must freeze; high in every state except IDLE.
- `out_valid` out 1: `out_data` holds a byte.
- `out_ready` in 1: sink accepts the byte.
- `out_data` out 8: ASCII byte.
- `halted` out 1: sticky exit indication.
- `exit_code` out 32: valid while `halted`.
- `unknown` out 1: one-cycle pulse when an unsupported code is accepted.

## Operation

- A request is accepted when `req_valid && req_ready` at a rising edge. Code and argument are latched on that edge.
- FSM states: IDLE, CHAR, SIGN, DIV, EMIT, HALT.
- PRINT_CHAR: IDLE -> CHAR. Drive `out_data = arg[7:0]` with `out_valid` high. Return to IDLE on the handshake.
- PRINT_INT with `arg[31]` = 1: IDLE -> SIGN. Emit `'-'` (0x2D). On the handshake go to DIV with magnitude = two's-complement negation treated as unsigned, so 0x80000000 gives 2147483648.
- PRINT_INT with `arg[31]` = 0: IDLE -> DIV with magnitude = arg.
- DIV: sequential restoring divide by 10, one quotient bit per cycle, 32 cycles per digit.
  - At the end of each digit, push the remainder onto a 10-entry digit stack and set magnitude = quotient.
  - If the quotient is 0, go to EMIT; otherwise start the next digit.
  - Value 0 yields exactly one digit, `'0'`.
- EMIT: pop the stack top (most significant digit first) and drive `out_data = 0x30 + digit`. Pop on each handshake. When the stack empties after the last handshake, go to IDLE.
- The stack never overflows: 2^32-1 needs at most 10 digits.
- EXIT / EXIT2: IDLE -> HALT. `exit_code` = 0 for EXIT, latched arg for EXIT2. `halted` = 1.
- HALT is terminal until reset. In HALT, `req_ready` = 0 and `stall` = 1.
- Any other code: `unknown` pulses for one cycle after acceptance, and the state stays IDLE. The request is consumed and no bytes are emitted.
- `out_data` and `out_valid` are registered and stable while `out_valid` is high and `out_ready` is low. `out_valid` never drops without a handshake, except on reset.

## Timing

- Reset values: state IDLE, `req_ready` 1, `stall` 0, `out_valid` 0, `out_data` 0, `halted` 0, `exit_code` 0, `unknown` 0, digit stack empty.
- Assertion of `reset_n` clears all of the above immediately, mid-service included. Any in-flight byte is dropped.
- Acceptance at edge N: `stall` is high and `req_ready` is low from N+1.
- PRINT_CHAR: `out_valid` high from N+1. If `out_ready` is held high, the handshake occurs at edge N+1 and `req_ready` returns at N+2.
- PRINT_INT, nonnegative, d digits, `out_ready` held high:
  - DIV occupies 32·d cycles.
  - The first digit is valid on the cycle after DIV ends.
  - One byte per cycle after that.
  - `req_ready` returns the cycle after the last handshake.
- Negative values add one SIGN cycle before DIV when `out_ready` is high.
- Backpressure on `out_ready` stretches SIGN, CHAR and EMIT cycle-for-cycle. DIV is unaffected.
- Exit: `halted` and `exit_code` are valid from N+1.
- `unknown` is high exactly at cycle N+1.
- `req_valid` outside IDLE is ignored; the core is stalled, so it re-presents the request later.

## Test plan

- PRINT_CHAR, arg 0x41, `out_ready` = 1 -> single byte 0x41 at N+1; `req_ready` back at N+2; `stall` high for exactly one cycle.
- PRINT_INT with args 0, 123 and 2147483647 -> byte streams "0", "123" and "2147483647"; first byte of "123" appears 97 cycles after acceptance.
- PRINT_INT with args -5 and 0x80000000 -> "-5" and "-2147483648"; `'-'` precedes all DIV cycles.
- PRINT_INT 4096 with `out_ready` toggled pseudo-randomly -> exactly "4096", no duplicated or lost bytes; `out_data` stable while stalled by the sink.
- EXIT2 arg 42, then EXIT via a fresh reset -> `halted` = 1 with `exit_code` 42, later 0. Further requests are not accepted; `stall` stays 1.
- Unknown code 99 -> one-cycle `unknown`, no output, `req_ready` high the next cycle. Reset pulsed mid-DIV of print 12345 -> all outputs at reset values, no bytes emitted, next request serviced normally.
